// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, coordinate width and receiver FSM encoding.
package vga_timing_pkg;

    localparam int unsigned COORD_W         = 12;

    localparam int unsigned H_TOTAL_DEF     = 800;
    localparam int unsigned H_SYNC_DEF      = 96;
    localparam int unsigned H_BP_DEF        = 48;
    localparam int unsigned H_ACTIVE_DEF    = 640;
    localparam int unsigned V_TOTAL_DEF     = 525;
    localparam int unsigned V_SYNC_DEF      = 2;
    localparam int unsigned V_BP_DEF        = 33;
    localparam int unsigned V_ACTIVE_DEF    = 480;
    localparam int unsigned LOCK_FRAMES_DEF = 2;

    localparam logic [COORD_W-1:0] COORD_MAX = 12'hFFF;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } sync_state_e;

    // Position counters stick at their maximum instead of wrapping, so a
    // missing sync can never alias into a plausible coordinate.
    function automatic logic [COORD_W-1:0] coord_sat_inc(input logic [COORD_W-1:0] v);
        if (v == COORD_MAX) begin
            return v;
        end else begin
            return v + 12'd1;
        end
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Normalises one sync line to "asserted" polarity and reports assert /
// deassert edges relative to the level seen at the previous pixel strobe.
module sync_edge_detect
    import vga_timing_pkg::*;
#(
    parameter bit SYNC_POL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pix_en,
    input  logic sync_in,
    output logic assert_edge,
    output logic deassert_edge
);

    logic sync_a_s;
    logic prev_d;
    logic prev_q;

    assign sync_a_s      = (sync_in == SYNC_POL);
    assign assert_edge   = pix_en &  sync_a_s & ~prev_q;
    assign deassert_edge = pix_en & ~sync_a_s &  prev_q;

    // History only advances on pixel strobes; anything between strobes is ignored.
    always_comb begin
        prev_d = prev_q;
        if (pix_en) begin
            prev_d = sync_a_s;
        end else begin
            prev_d = prev_q;
        end
    end

    // Previous-sample register, cleared to "not asserted".
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/vga_sync_receiver.sv
// Recovers pixel coordinates and active-video enable from hsync/vsync,
// checks every line and frame against the nominal timing and tracks lock.
module vga_sync_receiver
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_TOTAL     = H_TOTAL_DEF,
    parameter int unsigned H_SYNC      = H_SYNC_DEF,
    parameter int unsigned H_BP        = H_BP_DEF,
    parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
    parameter int unsigned V_TOTAL     = V_TOTAL_DEF,
    parameter int unsigned V_SYNC      = V_SYNC_DEF,
    parameter int unsigned V_BP        = V_BP_DEF,
    parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
    parameter bit          SYNC_POL    = 1'b0,
    parameter int unsigned LOCK_FRAMES = LOCK_FRAMES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
    input  logic               hsync,
    input  logic               vsync,
    output logic [COORD_W-1:0] h_cnt,
    output logic [COORD_W-1:0] v_cnt,
    output logic               enable,
    output logic               locked,
    output logic               frame_start,
    output logic               sync_err,
    output logic [7:0]         err_cnt
);

    localparam logic [12:0] H_TOTAL_C = 13'(H_TOTAL);
    localparam logic [12:0] H_SYNC_C  = 13'(H_SYNC);
    localparam logic [12:0] V_TOTAL_C = 13'(V_TOTAL);
    localparam logic [11:0] H_START   = 12'(H_SYNC + H_BP);
    localparam logic [11:0] H_STOP    = 12'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [11:0] V_START   = 12'(V_SYNC + V_BP);
    localparam logic [11:0] V_STOP    = 12'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [7:0]  LOCK_C    = 8'(LOCK_FRAMES);

    logic hs_rise_s, hs_fall_s, vs_rise_s;
    // Vsync width is informational, so its deassert edge is not consumed.
    logic vs_fall_unused_s;

    sync_edge_detect #(.SYNC_POL(SYNC_POL)) u_hs_edge (
        .clk(clk), .rst(rst), .pix_en(pix_en), .sync_in(hsync),
        .assert_edge(hs_rise_s), .deassert_edge(hs_fall_s)
    );

    sync_edge_detect #(.SYNC_POL(SYNC_POL)) u_vs_edge (
        .clk(clk), .rst(rst), .pix_en(pix_en), .sync_in(vsync),
        .assert_edge(vs_rise_s), .deassert_edge(vs_fall_unused_s)
    );

    logic [COORD_W-1:0] h_pos_d, h_pos_q, v_pos_d, v_pos_q;
    logic [COORD_W-1:0] h_cnt_d, h_cnt_q, v_cnt_d, v_cnt_q;
    sync_state_e        state_d, state_q;
    logic [7:0]         good_d, good_q, err_cnt_d, err_cnt_q;
    logic               enable_d, enable_q, locked_d, locked_q;
    logic               frame_start_d, frame_start_q, sync_err_d, sync_err_q;

    logic [12:0] h_len_s, v_len_s;
    logic        checking_s, line_err_s, width_err_s, frame_err_s, align_err_s, err_any_s;
    logic        in_h_s, in_v_s;

    // Lengths are "position of the last pixel + 1", widened so 4095+1 cannot wrap.
    assign h_len_s     = {1'b0, h_pos_q} + 13'd1;
    assign v_len_s     = {1'b0, v_pos_q} + 13'd1;
    assign checking_s  = (state_q != ST_SEARCH);
    assign line_err_s  = hs_rise_s && (h_len_s != H_TOTAL_C);
    assign width_err_s = hs_fall_s && (h_len_s != H_SYNC_C);
    assign frame_err_s = vs_rise_s && (v_len_s != V_TOTAL_C);
    // Alignment is checked even while searching, so a skewed vsync never locks.
    assign align_err_s = vs_rise_s && !hs_rise_s;
    assign err_any_s   = align_err_s || (checking_s && (line_err_s || width_err_s || frame_err_s));

    // Horizontal/vertical position counters; vsync edge overrides the line increment.
    always_comb begin
        h_pos_d = h_pos_q;
        v_pos_d = v_pos_q;
        if (pix_en) begin
            if (hs_rise_s) begin
                h_pos_d = 12'd0;
            end else begin
                h_pos_d = coord_sat_inc(h_pos_q);
            end
            if (vs_rise_s) begin
                v_pos_d = 12'd0;
            end else if (hs_rise_s) begin
                v_pos_d = coord_sat_inc(v_pos_q);
            end else begin
                v_pos_d = v_pos_q;
            end
        end else begin
            h_pos_d = h_pos_q;
            v_pos_d = v_pos_q;
        end
    end

    // Lock FSM next state: clean frames count up to lock, any error falls back to search.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            ST_SEARCH: begin
                if (vs_rise_s && hs_rise_s) begin
                    state_d = ST_CHECK;
                    good_d  = 8'd0;
                end else begin
                    state_d = ST_SEARCH;
                end
            end
            ST_CHECK: begin
                if (err_any_s) begin
                    state_d = ST_SEARCH;
                end else if (vs_rise_s) begin
                    good_d = good_q + 8'd1;
                    if ((good_q + 8'd1) == LOCK_C) begin
                        state_d = ST_LOCKED;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_LOCKED: begin
                if (err_any_s) begin
                    state_d = ST_SEARCH;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_SEARCH;
                good_d  = 8'd0;
            end
        endcase
    end

    assign in_h_s = (h_pos_d >= H_START) && (h_pos_d < H_STOP);
    assign in_v_s = (v_pos_d >= V_START) && (v_pos_d < V_STOP);

    // Output decode from the post-strobe position, held between strobes.
    always_comb begin
        locked_d      = (state_d == ST_LOCKED);
        frame_start_d = vs_rise_s;
        sync_err_d    = err_any_s;
        enable_d      = enable_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        if (err_any_s && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
        if (pix_en) begin
            enable_d = locked_d && in_h_s && in_v_s;
            if (enable_d) begin
                h_cnt_d = h_pos_d - H_START;
                v_cnt_d = v_pos_d - V_START;
            end else begin
                h_cnt_d = 12'd0;
                v_cnt_d = 12'd0;
            end
        end else begin
            enable_d = enable_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_pos_q       <= 12'd0;
            v_pos_q       <= 12'd0;
            state_q       <= ST_SEARCH;
            good_q        <= 8'd0;
            err_cnt_q     <= 8'd0;
            enable_q      <= 1'b0;
            locked_q      <= 1'b0;
            h_cnt_q       <= 12'd0;
            v_cnt_q       <= 12'd0;
            frame_start_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            h_pos_q       <= h_pos_d;
            v_pos_q       <= v_pos_d;
            state_q       <= state_d;
            good_q        <= good_d;
            err_cnt_q     <= err_cnt_d;
            enable_q      <= enable_d;
            locked_q      <= locked_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_start_q <= frame_start_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign h_cnt       = h_cnt_q;
    assign v_cnt       = v_cnt_q;
    assign enable      = enable_q;
    assign locked      = locked_q;
    assign frame_start = frame_start_q;
    assign sync_err    = sync_err_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver using a shrunken timing so whole frames are cheap.
// A pixel-index/timestamp reference model predicts every output on every clock.
module tb_vga_sync_receiver;

    localparam int HT = 30, HS = 4, HBP = 3, HA = 20;
    localparam int VT = 16, VS = 2, VBP = 2, VA = 10;
    localparam int LF = 2;
    localparam bit SYNC_POL = 1'b0;
    localparam int S_SEARCH = 0, S_CHECK = 1, S_LOCKED = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_en = 1'b0;
    logic        hsync = ~SYNC_POL;
    logic        vsync = ~SYNC_POL;
    logic [11:0] h_cnt, v_cnt;
    logic        enable, locked, frame_start, sync_err;
    logic [7:0]  err_cnt;

    vga_sync_receiver #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA),
        .SYNC_POL(SYNC_POL), .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
        .h_cnt(h_cnt), .v_cnt(v_cnt), .enable(enable), .locked(locked),
        .frame_start(frame_start), .sync_err(sync_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    // reference model state
    int m_state, m_good, m_err, m_t, m_hst, m_lines;
    bit m_ph, m_pv;
    bit e_fs, e_se, e_lock, e_en;
    int e_h, e_v, e_ec;

    // stimulus bookkeeping and observations
    int max_gap = 2;
    int cur_x = -1, cur_y = -1;
    int wa_x = -1, wa_y = -1, wb_x = -1, wb_y = -1;
    bit cap_a_hit, cap_a_lock, cap_a_en, cap_b_hit, cap_b_en;
    int cap_a_h, cap_a_v, cap_b_h, cap_b_v;
    int se_seen = 0, en_after = 0;

    task automatic model_reset();
        m_state = S_SEARCH; m_good = 0; m_err = 0; m_t = 0; m_hst = -1; m_lines = 0;
        m_ph = 1'b0; m_pv = 1'b0;
        e_fs = 1'b0; e_se = 1'b0; e_lock = 1'b0; e_en = 1'b0; e_h = 0; e_v = 0; e_ec = 0;
    endtask

    task automatic model_pixel(input bit hs_a, input bit vs_a);
        bit hr, hf, vr, chk, err;
        int oh, ov, hp, vp;
        hr = hs_a && !m_ph;
        hf = !hs_a && m_ph;
        vr = vs_a && !m_pv;
        oh = (m_t - 1 - m_hst > 4095) ? 4095 : (m_t - 1 - m_hst);
        ov = m_lines;
        chk = (m_state != S_SEARCH);
        err = (vr && !hr) ||
              (chk && ((hr && oh + 1 != HT) || (hf && oh + 1 != HS) || (vr && ov + 1 != VT)));
        if (hr) m_hst = m_t;
        if (vr) m_lines = 0;
        else if (hr && m_lines < 4095) m_lines++;
        if (m_state == S_SEARCH) begin
            if (vr && hr) begin m_state = S_CHECK; m_good = 0; end
        end else if (err) begin
            m_state = S_SEARCH;
        end else if (m_state == S_CHECK && vr) begin
            m_good++;
            if (m_good == LF) m_state = S_LOCKED;
        end
        m_ph = hs_a; m_pv = vs_a;
        if (err && m_err < 255) m_err++;
        hp = (m_t - m_hst > 4095) ? 4095 : (m_t - m_hst);
        vp = m_lines;
        e_lock = (m_state == S_LOCKED);
        e_en = e_lock && hp >= HS + HBP && hp < HS + HBP + HA && vp >= VS + VBP && vp < VS + VBP + VA;
        e_h = e_en ? hp - (HS + HBP) : 0;
        e_v = e_en ? vp - (VS + VBP) : 0;
        e_fs = vr; e_se = err; e_ec = m_err;
        m_t++;
    endtask

    // One clock: drive at negedge, sample 1 time unit after posedge, compare to model.
    task automatic cycle(input bit pe, input bit hs_as, input bit vs_as, input bit do_rst);
        logic [35:0] act, exp_v;
        @(negedge clk);
        rst = do_rst;
        pix_en = pe;
        hsync = hs_as ? SYNC_POL : ~SYNC_POL;
        vsync = vs_as ? SYNC_POL : ~SYNC_POL;
        @(posedge clk);
        #1;
        if (do_rst) model_reset();
        else if (pe) model_pixel(hs_as, vs_as);
        else begin e_fs = 1'b0; e_se = 1'b0; end
        act = {frame_start, sync_err, locked, enable, h_cnt, v_cnt, err_cnt};
        exp_v = {e_fs, e_se, e_lock, e_en, 12'(e_h), 12'(e_v), 8'(e_ec)};
        compared++;
        if (act !== exp_v) begin
            mismatched++;
            $display("FAIL cycle_model t=%0t got fs=%0b se=%0b lk=%0b en=%0b h=%0d v=%0d ec=%0d exp fs=%0b se=%0b lk=%0b en=%0b h=%0d v=%0d ec=%0d",
                     $time, frame_start, sync_err, locked, enable, h_cnt, v_cnt, err_cnt,
                     e_fs, e_se, e_lock, e_en, e_h, e_v, e_ec);
        end
        if (sync_err === 1'b1) se_seen++;
        if (se_seen > 0 && enable === 1'b1) en_after++;
        if (pe && !do_rst && cur_x == wa_x && cur_y == wa_y) begin
            cap_a_hit = 1'b1; cap_a_lock = locked; cap_a_en = enable; cap_a_h = h_cnt; cap_a_v = v_cnt;
        end
        if (pe && !do_rst && cur_x == wb_x && cur_y == wb_y) begin
            cap_b_hit = 1'b1; cap_b_en = enable; cap_b_h = h_cnt; cap_b_v = v_cnt;
        end
    endtask

    task automatic do_reset_cycle();
        cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b1);
        se_seen = 0;
        en_after = 0;
    endtask

    // Random idle gap (with garbage syncs) then one strobed pixel.
    task automatic send_pixel(input bit hs_a, input bit vs_a);
        int gap;
        gap = $urandom_range(0, max_gap);
        repeat (gap) cycle(1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b0);
        cycle(1'b1, hs_a, vs_a, 1'b0);
    endtask

    task automatic send_frame(input int nlines, input int vs_shift, input int vs_len,
                              input int bad_line, input int bad_len, input int bad_hsw,
                              input int rst_line, input int rst_x);
        int p;
        p = 0;
        for (int l = 0; l < nlines; l++) begin
            int len;
            int hw;
            len = (l == bad_line) ? bad_len : HT;
            hw  = (l == bad_line) ? bad_hsw : HS;
            for (int x = 0; x < len; x++) begin
                if (l == rst_line && x == rst_x) do_reset_cycle();
                cur_x = x;
                cur_y = l;
                send_pixel(x < hw, (p >= vs_shift) && (p < vs_shift + vs_len));
                p++;
            end
        end
        cur_x = -1;
        cur_y = -1;
    endtask

    task automatic clean_frames(input int n);
        for (int i = 0; i < n; i++) send_frame(VT, 0, VS * HT, -1, 0, 0, -1, 0);
    endtask

    task automatic expect_bit(input string name, input logic got, input logic want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %0b expected %0b", name, got, want);
        end
    endtask

    task automatic test_reset();
        repeat (3) do_reset_cycle();
        compared++;
        if ({frame_start, sync_err, locked, enable, h_cnt, v_cnt, err_cnt} !== 36'd0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %h expected 0", {frame_start, sync_err, locked, enable, h_cnt, v_cnt, err_cnt});
        end
    endtask

    task automatic test_nominal_lock();
        wa_x = 0; wa_y = 0; cap_a_hit = 1'b0;
        clean_frames(2);
        compared++;
        if (cap_a_hit !== 1'b1 || cap_a_lock !== 1'b0) begin
            mismatched++;
            $display("FAIL lock_after_2nd_edge: hit=%0b locked=%0b expected hit=1 locked=0", cap_a_hit, cap_a_lock);
        end
        cap_a_hit = 1'b0;
        clean_frames(1);
        compared++;
        if (cap_a_hit !== 1'b1 || cap_a_lock !== 1'b1) begin
            mismatched++;
            $display("FAIL lock_after_3rd_edge: hit=%0b locked=%0b expected hit=1 locked=1", cap_a_hit, cap_a_lock);
        end
        wa_x = HS + HBP; wa_y = VS + VBP; cap_a_hit = 1'b0;
        wb_x = HS + HBP + HA - 1; wb_y = VS + VBP + VA - 1; cap_b_hit = 1'b0;
        clean_frames(1);
        compared++;
        if (cap_a_hit !== 1'b1 || cap_a_en !== 1'b1 || cap_a_h != 0 || cap_a_v != 0) begin
            mismatched++;
            $display("FAIL first_active_pixel: en=%0b h=%0d v=%0d expected en=1 h=0 v=0", cap_a_en, cap_a_h, cap_a_v);
        end
        compared++;
        if (cap_b_hit !== 1'b1 || cap_b_en !== 1'b1 || cap_b_h != HA - 1 || cap_b_v != VA - 1) begin
            mismatched++;
            $display("FAIL last_active_pixel: en=%0b h=%0d v=%0d expected en=1 h=%0d v=%0d", cap_b_en, cap_b_h, cap_b_v, HA - 1, VA - 1);
        end
        wa_x = -1; wb_x = -1;
    endtask

    task automatic relock_check(input string name);
        clean_frames(2);
        expect_bit({name, "_not_yet_locked"}, locked, 1'b0);
        clean_frames(1);
        expect_bit({name, "_relocked"}, locked, 1'b1);
    endtask

    task automatic test_line_fault();
        se_seen = 0;
        send_frame(VT, 0, VS * HT, $urandom_range(1, VT - 2), HT + 1, HS, -1, 0);
        compared++;
        if (se_seen != 1 || err_cnt !== 8'd1) begin
            mismatched++;
            $display("FAIL line_fault: pulses=%0d err_cnt=%0d expected pulses=1 err_cnt=1", se_seen, err_cnt);
        end
        expect_bit("line_fault_unlock", locked, 1'b0);
        relock_check("line_fault");
    endtask

    task automatic test_hsync_width();
        se_seen = 0; en_after = 0;
        send_frame(VT, 0, VS * HT, $urandom_range(VS + VBP, VS + VBP + VA - 2), HT, HS - 1, -1, 0);
        compared++;
        if (se_seen != 1 || err_cnt !== 8'd2 || en_after != 0) begin
            mismatched++;
            $display("FAIL hsync_width: pulses=%0d err_cnt=%0d enable_after=%0d expected 1 2 0", se_seen, err_cnt, en_after);
        end
        expect_bit("hsync_width_unlock", locked, 1'b0);
        relock_check("hsync_width");
    endtask

    task automatic test_misaligned();
        do_reset_cycle();
        send_frame(VT, 10, VS * HT, -1, 0, 0, -1, 0);
        compared++;
        if (se_seen != 1 || err_cnt !== 8'd1 || locked !== 1'b0) begin
            mismatched++;
            $display("FAIL misaligned_vsync: pulses=%0d err_cnt=%0d locked=%0b expected 1 1 0", se_seen, err_cnt, locked);
        end
        relock_check("misaligned");
    endtask

    task automatic test_reset_mid_frame();
        send_frame(VT, 0, VS * HT, -1, 0, 0, 8, $urandom_range(0, HT - 1));
        compared++;
        if (se_seen != 0 || err_cnt !== 8'd0 || locked !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_mid_frame: pulses=%0d err_cnt=%0d locked=%0b expected 0 0 0", se_seen, err_cnt, locked);
        end
        relock_check("reset_mid_frame");
    endtask

    task automatic test_saturation();
        do_reset_cycle();
        max_gap = 0;
        for (int i = 0; i < 300; i++) begin
            send_frame(2, 0, HT, -1, 0, 0, -1, 0);
            send_frame(2, 0, HT, -1, 0, 0, -1, 0);
        end
        max_gap = 2;
        compared++;
        if (se_seen != 300 || err_cnt !== 8'd255) begin
            mismatched++;
            $display("FAIL saturation: pulses=%0d err_cnt=%0d expected 300 255", se_seen, err_cnt);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_nominal_lock();
        test_line_fault();
        test_hsync_width();
        test_misaligned();
        test_reset_mid_frame();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
